// File: rtl/if_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package if_pkg;

   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_HALT  = 2'd1,
      S_FAULT = 2'd2
   } fetch_state_e;

   localparam logic [1:0] CAUSE_NONE     = 2'b00;
   localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
   localparam logic [1:0] CAUSE_RANGE    = 2'b10;

   localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

endpackage

// File: rtl/if_stage_if.sv
// Bus bundle between the fetch stage, instruction memory, redirect logic and decode.
interface if_stage_if;

   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_ready;
   logic        out_valid;
   logic [31:0] out_pc;
   logic [31:0] out_pc_plus4;
   logic [31:0] out_instr;
   logic        halted;
   logic        fault;
   logic [1:0]  fault_cause;

   modport master (
      output imem_addr, out_valid, out_pc, out_pc_plus4, out_instr,
             halted, fault, fault_cause,
      input  imem_instr, redirect_valid, redirect_pc, id_ready
   );

   modport slave (
      input  imem_addr, out_valid, out_pc, out_pc_plus4, out_instr,
             halted, fault, fault_cause,
      output imem_instr, redirect_valid, redirect_pc, id_ready
   );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: loads a fetched word, holds when idle, flushes to a NOP bubble.
module if_id_reg
   import if_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        flush,
   input  logic [31:0] in_pc,
   input  logic [31:0] in_instr,
   output logic        valid,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic [31:0] instr
);

   logic        valid_q, valid_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pc_plus4_q, pc_plus4_d;
   logic [31:0] instr_q, instr_d;

   always_comb begin
      valid_d    = valid_q;
      pc_d       = pc_q;
      pc_plus4_d = pc_plus4_q;
      instr_d    = instr_q;
      // A bubble always carries the NOP so decode never sees stale bits.
      if (flush) begin
         valid_d = 1'b0;
         instr_d = NOP_INSTR;
      end else if (load) begin
         valid_d    = 1'b1;
         pc_d       = in_pc;
         pc_plus4_d = in_pc + 32'd4;
         instr_d    = in_instr;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q    <= 1'b0;
         pc_q       <= 32'd0;
         pc_plus4_q <= 32'd0;
         instr_q    <= NOP_INSTR;
      end else begin
         valid_q    <= valid_d;
         pc_q       <= pc_d;
         pc_plus4_q <= pc_plus4_d;
         instr_q    <= instr_d;
      end
   end

   assign valid    = valid_q;
   assign pc       = pc_q;
   assign pc_plus4 = pc_plus4_q;
   assign instr    = instr_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, handles redirect/stall/halt/fault, feeds the IF/ID register.
module if_stage
   import if_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
   parameter int          IMEM_WORDS = 2048,
   parameter logic [31:0] NOP_INSTR  = NOP_INSTR_DEF
) (
   input  logic        clk,
   input  logic        rst,
   if_stage_if.master  bus
);

   localparam logic [29:0] IMEM_LIMIT = 30'(IMEM_WORDS);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [1:0]   cause_q, cause_d;
   logic         load, flush, adv;
   logic         out_valid;

   assign adv = !out_valid || bus.id_ready;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cause_d = cause_q;
      load    = 1'b0;
      flush   = 1'b0;
      unique case (state_q)
         S_RUN: begin
            if (bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00)) begin
               state_d = S_FAULT;
               cause_d = CAUSE_MISALIGN;
               flush   = 1'b1;
            end else if (bus.redirect_valid) begin
               // Redirect wins over a stalled decode: the flushed word is wrong-path.
               pc_d  = bus.redirect_pc;
               flush = 1'b1;
            end else if (pc_q[31:2] >= IMEM_LIMIT) begin
               state_d = S_FAULT;
               cause_d = CAUSE_RANGE;
               flush   = 1'b1;
            end else if (adv) begin
               if (bus.imem_instr == 32'd0) begin
                  state_d = S_HALT;
                  flush   = 1'b1;
               end else begin
                  load = 1'b1;
                  pc_d = pc_q + 32'd4;
               end
            end
         end
         S_HALT: begin
            flush = 1'b1;
            if (bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00)) begin
               state_d = S_FAULT;
               cause_d = CAUSE_MISALIGN;
            end else if (bus.redirect_valid) begin
               pc_d    = bus.redirect_pc;
               state_d = S_RUN;
            end
         end
         S_FAULT: flush = 1'b1;
         default: begin
            state_d = S_FAULT;
            flush   = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_RUN;
         pc_q    <= RESET_PC;
         cause_q <= CAUSE_NONE;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cause_q <= cause_d;
      end
   end

   if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id_reg (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .flush    (flush),
      .in_pc    (pc_q),
      .in_instr (bus.imem_instr),
      .valid    (out_valid),
      .pc       (bus.out_pc),
      .pc_plus4 (bus.out_pc_plus4),
      .instr    (bus.out_instr)
   );

   assign bus.out_valid   = out_valid;
   assign bus.imem_addr   = pc_q;
   assign bus.halted      = (state_q == S_HALT);
   assign bus.fault       = (state_q == S_FAULT);
   assign bus.fault_cause = cause_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: run, stall, redirect, halt, faults and reset recovery.
module tb_if_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;
   logic [31:0] mem [0:2047];

   if_stage_if bus ();

   if_stage #(
      .RESET_PC   (32'h0000_0000),
      .IMEM_WORDS (2048),
      .NOP_INSTR  (NOP)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Combinational instruction memory; out-of-range addresses read zero.
   always_comb begin
      bus.imem_instr = 32'd0;
      if (bus.imem_addr[31:13] == 19'd0)
         bus.imem_instr = mem[bus.imem_addr[12:2]];
   end

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp_v);
      end
   endtask

   task automatic chk_state(input string name, input logic v, input logic h,
                            input logic f, input logic [1:0] c);
      n_checks++;
      if ({bus.out_valid, bus.halted, bus.fault, bus.fault_cause} !== {v, h, f, c}) begin
         n_fail++;
         $display("FAIL %s: got valid=%b halted=%b fault=%b cause=%b expected valid=%b halted=%b fault=%b cause=%b",
                  name, bus.out_valid, bus.halted, bus.fault, bus.fault_cause, v, h, f, c);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.id_ready = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = 32'd0;
      @(negedge clk);
      @(negedge clk);
      chk_state("reset_flags", 1'b0, 1'b0, 1'b0, 2'b00);
      chk32("reset_out_pc", bus.out_pc, 32'd0);
      chk32("reset_out_pc_plus4", bus.out_pc_plus4, 32'd0);
      chk32("reset_out_instr", bus.out_instr, NOP);
      chk32("reset_imem_addr", bus.imem_addr, 32'd0);
      $display("reset: imem_addr=%h out_valid=%b", bus.imem_addr, bus.out_valid);
      rst = 1'b0;
   endtask

   task automatic test_run();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         $display("run: out_pc=%h out_instr=%h imem_addr=%h", bus.out_pc, bus.out_instr, bus.imem_addr);
         chk_state("run_valid", 1'b1, 1'b0, 1'b0, 2'b00);
         chk32("run_out_pc", bus.out_pc, 32'(4 * k));
         chk32("run_out_pc_plus4", bus.out_pc_plus4, 32'(4 * k + 4));
         chk32("run_out_instr", bus.out_instr, mem[k]);
         chk32("run_imem_addr", bus.imem_addr, 32'(4 * k + 4));
      end
   endtask

   task automatic test_stall();
      bus.id_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         $display("stall: out_pc=%h imem_addr=%h", bus.out_pc, bus.imem_addr);
         chk_state("stall_valid", 1'b1, 1'b0, 1'b0, 2'b00);
         chk32("stall_out_pc", bus.out_pc, 32'h8);
         chk32("stall_out_instr", bus.out_instr, mem[2]);
         chk32("stall_imem_addr", bus.imem_addr, 32'hC);
      end
      bus.id_ready = 1'b1;
      @(negedge clk);
      chk32("stall_release_out_pc", bus.out_pc, 32'hC);
      chk32("stall_release_imem_addr", bus.imem_addr, 32'h10);
   endtask

   task automatic test_redirect_stall();
      bus.id_ready = 1'b0;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h40;
      @(negedge clk);
      bus.redirect_valid = 1'b0;
      $display("redirect: out_valid=%b imem_addr=%h", bus.out_valid, bus.imem_addr);
      chk_state("redir_flush", 1'b0, 1'b0, 1'b0, 2'b00);
      chk32("redir_imem_addr", bus.imem_addr, 32'h40);
      chk32("redir_nop", bus.out_instr, NOP);
      @(negedge clk);
      chk_state("redir_load", 1'b1, 1'b0, 1'b0, 2'b00);
      chk32("redir_out_pc", bus.out_pc, 32'h40);
      chk32("redir_out_instr", bus.out_instr, mem[16]);
      bus.id_ready = 1'b1;
   endtask

   task automatic test_halt();
      int cycles;
      cycles = 0;
      while (!bus.halted && cycles < 40) begin
         @(negedge clk);
         cycles++;
      end
      $display("halt: after %0d cycles imem_addr=%h", cycles, bus.imem_addr);
      chk32("halt_cycles", 32'(cycles), 32'd10);
      chk_state("halt_flags", 1'b0, 1'b1, 1'b0, 2'b00);
      chk32("halt_imem_addr", bus.imem_addr, 32'h68);
      chk32("halt_nop", bus.out_instr, NOP);
      @(negedge clk);
      chk_state("halt_hold", 1'b0, 1'b1, 1'b0, 2'b00);
      chk32("halt_hold_addr", bus.imem_addr, 32'h68);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h0;
      @(negedge clk);
      bus.redirect_valid = 1'b0;
      chk_state("unhalt_flags", 1'b0, 1'b0, 1'b0, 2'b00);
      chk32("unhalt_imem_addr", bus.imem_addr, 32'h0);
      @(negedge clk);
      chk_state("resume_valid", 1'b1, 1'b0, 1'b0, 2'b00);
      chk32("resume_out_pc", bus.out_pc, 32'h0);
      chk32("resume_out_instr", bus.out_instr, mem[0]);
   endtask

   task automatic test_misalign();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h42;
      @(negedge clk);
      bus.redirect_valid = 1'b0;
      $display("misalign: fault=%b cause=%b imem_addr=%h", bus.fault, bus.fault_cause, bus.imem_addr);
      chk_state("misalign_flags", 1'b0, 1'b0, 1'b1, 2'b01);
      chk32("misalign_pc_frozen", bus.imem_addr, 32'h4);
      repeat (3) @(negedge clk);
      chk_state("misalign_sticky", 1'b0, 1'b0, 1'b1, 2'b01);
      chk32("misalign_nop", bus.out_instr, NOP);
      // An aligned redirect must not revive a faulted stage.
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h0;
      @(negedge clk);
      bus.redirect_valid = 1'b0;
      chk_state("fault_ignores_redirect", 1'b0, 1'b0, 1'b1, 2'b01);
      chk32("fault_ignores_redirect_pc", bus.imem_addr, 32'h4);
   endtask

   task automatic test_range();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h1FFC;
      @(negedge clk);
      bus.redirect_valid = 1'b0;
      chk32("range_redir_addr", bus.imem_addr, 32'h1FFC);
      chk_state("range_redir_flags", 1'b0, 1'b0, 1'b0, 2'b00);
      @(negedge clk);
      chk_state("range_last_valid", 1'b1, 1'b0, 1'b0, 2'b00);
      chk32("range_last_pc", bus.out_pc, 32'h1FFC);
      chk32("range_last_instr", bus.out_instr, mem[2047]);
      chk32("range_next_addr", bus.imem_addr, 32'h2000);
      @(negedge clk);
      $display("range: fault=%b cause=%b imem_addr=%h", bus.fault, bus.fault_cause, bus.imem_addr);
      chk_state("range_fault", 1'b0, 1'b0, 1'b1, 2'b10);
      chk32("range_fault_addr", bus.imem_addr, 32'h2000);
   endtask

   task automatic test_reset_in_fault();
      bus.id_ready = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      $display("reset_in_fault: fault=%b imem_addr=%h", bus.fault, bus.imem_addr);
      chk_state("rst_fault_flags", 1'b0, 1'b0, 1'b0, 2'b00);
      chk32("rst_fault_addr", bus.imem_addr, 32'h0);
      chk32("rst_fault_out_pc", bus.out_pc, 32'h0);
      chk32("rst_fault_instr", bus.out_instr, NOP);
      bus.id_ready = 1'b1;
      @(negedge clk);
      chk32("rst_fault_refetch", bus.out_instr, mem[0]);
   endtask

   initial begin
      n_checks = 0;
      n_fail = 0;
      for (int i = 0; i < 2048; i++) mem[i] = 32'h0000_0013 | (32'(i) << 20);
      mem[0] = 32'h0050_0093;
      mem[1] = 32'h0010_0113;
      mem[26] = 32'h0000_0000;
      rst = 1'b1;
      bus.id_ready = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = 32'd0;
      test_reset();
      test_run();
      test_stall();
      test_redirect_stall();
      test_halt();
      test_misalign();
      test_range();
      test_reset_in_fault();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage; sits directly upstream of instr_mem and downstream of the branch/jump resolution logic.
- Owns the program counter and drives the word-aligned byte address into instruction memory.
- Captures the combinationally returned instruction word into an IF/ID pipeline register, with a valid/ready handshake toward decode.
- Handles redirects (flush), stalls, halting on zero-padded memory, and fetch faults.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_WORDS, 2048, number of addressable instruction words; PCs at or beyond IMEM_WORDS*4 fault.
- NOP_INSTR, 32'h0000_0013, value of out_instr whenever out_valid=0 (addi x0,x0,0).

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- imem_addr  out  32  byte address to instruction memory; equals pc register (combinational)
- imem_instr  in  32  instruction word returned by memory in the same cycle
- redirect_valid  in  1  branch/jump taken; flush and reload PC
- redirect_pc  in  32  target byte address
- id_ready  in  1  decode accepts out_* this cycle
- out_valid  out  1  IF/ID register holds a valid instruction
- out_pc  out  32  PC of out_instr
- out_pc_plus4  out  32  out_pc + 4
- out_instr  out  32  fetched instruction
- halted  out  1  fetch stopped on all-zero word
- fault  out  1  sticky fetch fault
- fault_cause  out  2  01 misaligned redirect, 10 PC out of range, 00 none

Behaviour:
- Reset (rst=1 at edge, overrides everything, including mid-stall or mid-redirect):
  - pc=RESET_PC, state=S_RUN.
  - out_valid=0, out_pc=0, out_pc_plus4=0, out_instr=NOP_INSTR.
  - halted=0, fault=0, fault_cause=00.
- States: S_RUN, S_HALT, S_FAULT. Encoded in the shared package.
- Advance condition: adv = !out_valid || id_ready.
- S_RUN, priority order each edge:
  1. redirect_valid with redirect_pc[1:0]!=0 -> S_FAULT, fault_cause=01, out_valid<=0, pc unchanged.
  2. redirect_valid (aligned) -> pc<=redirect_pc, out_valid<=0. Flushes the register whether or not id_ready is asserted; the redirect is never lost.
  3. pc[31:2] >= IMEM_WORDS -> S_FAULT, fault_cause=10, out_valid<=0.
  4. adv with imem_instr==0 -> S_HALT, out_valid<=0, pc held.
  5. adv -> out_instr<=imem_instr, out_pc<=pc, out_pc_plus4<=pc+4, out_valid<=1, pc<=pc+4 (mod 2^32).
  6. Otherwise (stall): all registers hold.
- Latency: the instruction at PC p is presented on imem_addr in cycle n and appears on out_* in cycle n+1. Sustained throughput is one instruction per cycle while id_ready=1.
- S_HALT:
  - halted=1, out_valid=0.
  - Aligned in-range redirect -> pc<=redirect_pc, S_RUN, halted<=0.
  - Misaligned redirect -> S_FAULT, fault_cause=01.
- S_FAULT: fault=1, out_valid=0, pc frozen; exits only on rst.
- When out_valid=0, out_instr must read NOP_INSTR. When out_valid=1, out_* stay stable until accepted or flushed.
- Width rules: PC arithmetic is 32-bit unsigned and wraps. The range check uses pc[31:2] only.

Decomposition:
- Package if_pkg:
  - fetch-state enum (S_RUN/S_HALT/S_FAULT)
  - fault_cause codes
  - NOP_INSTR and RESET_PC defaults
- One natural sub-module: if_id_reg (IF/ID pipeline register with valid, hold and flush). The PC/FSM logic stays in if_stage.

Test Plan:
- Reset then run with memory words 0x00500093, 0x00100113, …, id_ready=1 -> imem_addr 0,4,8…; out_pc 0 with out_instr 0x00500093 one cycle after reset release, then one instruction per cycle.
- Hold id_ready=0 for 3 cycles while out_valid=1 at out_pc=8 -> out_* and imem_addr=0xC held stable; out_pc=0xC appears the cycle after id_ready returns to 1.
- redirect_valid=1, redirect_pc=0x40 while id_ready=0 and out_valid=1 -> next cycle out_valid=0, imem_addr=0x40; cycle after that out_pc=0x40.
- Execution reaches a zero word at 0x68 -> halted=1, out_valid=0, imem_addr stays 0x68; redirect to 0x0 -> halted=0 and fetch resumes at 0.
- redirect_pc=0x42 -> fault=1, fault_cause=01, no further valid output; redirect to 0x1FFC then advance past it -> fault_cause=10 at pc=0x2000.
- Assert rst during a stall with fault set -> all outputs return to reset values and imem_addr=RESET_PC on the next cycle.
